// File: rtl/nzcv_flag_if.sv
// ALU-side bus of the NZCV flag unit: update, save/restore, condition query and results.
interface nzcv_flag_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_CTX = 4
);
  localparam int CTX_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;

  logic             valid_in;
  logic [CTX_W-1:0] ctx_sel;
  logic [3:0]       op_code;
  logic             s_flag;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] result;
  logic             save;
  logic             restore;
  logic [CTX_W-1:0] cond_ctx;
  logic [3:0]       cond_code;
  logic [3:0]       flags_out;
  logic             flags_vld;
  logic             cond_pass;

  modport master (
    output valid_in, ctx_sel, op_code, s_flag, in1, in2, result,
           save, restore, cond_ctx, cond_code,
    input  flags_out, flags_vld, cond_pass
  );

  modport slave (
    input  valid_in, ctx_sel, op_code, s_flag, in1, in2, result,
           save, restore, cond_ctx, cond_code,
    output flags_out, flags_vld, cond_pass
  );
endinterface

// File: rtl/nzcv_flag_unit.sv
// Per-context NZCV flag registers with one-deep shadows, plus condition-code evaluation
// that sees the value being written this cycle.
module nzcv_flag_unit #(
  parameter int WIDTH   = 32,
  parameter int NUM_CTX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  nzcv_flag_if.slave  bus
);
  localparam int CTX_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;
  localparam int DEPTH = 1 << CTX_W;
  localparam logic [CTX_W:0] CTX_LIM = (CTX_W+1)'(NUM_CTX);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b1011;
  localparam logic [3:0] OP_NF  = 4'b1111;

  // Flag vector layout: {N, Z, C, V}
  logic [3:0] live_q   [DEPTH];
  logic [3:0] live_d   [DEPTH];
  logic [3:0] shadow_q [DEPTH];
  logic [3:0] shadow_d [DEPTH];
  logic [3:0] flags_out_q;
  logic       flags_vld_q;

  logic       ctx_ok, cond_ok;
  logic       is_add, is_sub, is_ld, is_nf;
  logic       upd, wr_live;
  logic       in1_s, in2_s, res_s;
  logic       cur_c, cur_v;
  logic [3:0] new_f;
  logic [3:0] eval_f;

  function automatic logic cond_eval(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (code)
      4'h0: cond_eval = z;
      4'h1: cond_eval = !z;
      4'h2: cond_eval = c;
      4'h3: cond_eval = !c;
      4'h4: cond_eval = n;
      4'h5: cond_eval = !n;
      4'h6: cond_eval = v;
      4'h7: cond_eval = !v;
      4'h8: cond_eval = c && !z;
      4'h9: cond_eval = !c || z;
      4'hA: cond_eval = (n == v);
      4'hB: cond_eval = (n != v);
      4'hC: cond_eval = !z && (n == v);
      4'hD: cond_eval = z || (n != v);
      4'hE: cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  always_comb begin
    ctx_ok  = ({1'b0, bus.ctx_sel}  < CTX_LIM);
    cond_ok = ({1'b0, bus.cond_ctx} < CTX_LIM);
    is_add  = (bus.op_code == OP_ADD);
    is_sub  = (bus.op_code == OP_SUB);
    is_ld   = (bus.op_code == OP_LD);
    is_nf   = (bus.op_code == OP_NF);
    upd     = bus.valid_in && ctx_ok && !is_nf && (is_ld || bus.s_flag);
    // restore wins over a same-cycle update to the same context
    wr_live = upd && !bus.restore;
    in1_s   = bus.in1[WIDTH-1];
    in2_s   = bus.in2[WIDTH-1];
    res_s   = bus.result[WIDTH-1];
    cur_c   = live_q[bus.ctx_sel][1];
    cur_v   = live_q[bus.ctx_sel][0];

    new_f = 4'b0000;
    if (is_ld) begin
      new_f = 4'(bus.result);
    end else begin
      new_f[3] = res_s;
      new_f[2] = (bus.result == '0);
      new_f[1] = is_add ? (bus.result < bus.in1) :
                 is_sub ? (bus.in1 >= bus.in2)   : cur_c;
      new_f[0] = is_add ? ((in1_s == in2_s) && (res_s != in1_s)) :
                 is_sub ? ((in1_s != in2_s) && (res_s != in1_s)) : cur_v;
    end
  end

  // save and restore both read pre-edge values, so asserting both swaps live and shadow
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      live_d[i]   = live_q[i];
      shadow_d[i] = shadow_q[i];
      if (ctx_ok && (CTX_W'(i) == bus.ctx_sel)) begin
        if (bus.save)    shadow_d[i] = live_q[i];
        if (bus.restore) live_d[i]   = shadow_q[i];
        else if (upd)    live_d[i]   = new_f;
      end
    end
  end

  // Next-state value of the queried context gives same-cycle bypass for dependent ops
  always_comb begin
    eval_f        = live_d[bus.cond_ctx];
    bus.cond_pass = cond_ok && cond_eval(bus.cond_code, eval_f);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        live_q[i]   <= 4'b0000;
        shadow_q[i] <= 4'b0000;
      end
      flags_out_q <= 4'b0000;
      flags_vld_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        live_q[i]   <= live_d[i];
        shadow_q[i] <= shadow_d[i];
      end
      if (wr_live) flags_out_q <= new_f;
      flags_vld_q <= wr_live;
    end
  end

  assign bus.flags_out = flags_out_q;
  assign bus.flags_vld = flags_vld_q;
endmodule

// File: tb/tb_nzcv_flag_unit.sv
// Directed bench for nzcv_flag_unit: a 32-bit/4-context instance and an 8-bit/3-context one.
module tb_nzcv_flag_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  nzcv_flag_if #(.WIDTH(32), .NUM_CTX(4)) bus ();
  nzcv_flag_if #(.WIDTH(8),  .NUM_CTX(3)) bus2 ();

  nzcv_flag_unit #(.WIDTH(32), .NUM_CTX(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  nzcv_flag_unit #(.WIDTH(8),  .NUM_CTX(3)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  task automatic drv(input logic v, input logic [1:0] ctx, input logic [3:0] op, input logic s,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
    bus.valid_in = v; bus.ctx_sel = ctx; bus.op_code = op; bus.s_flag = s;
    bus.in1 = a; bus.in2 = b; bus.result = r;
  endtask

  task automatic sr(input logic sv, input logic rs);
    bus.save = sv; bus.restore = rs;
  endtask

  task automatic cq(input logic [1:0] ctx, input logic [3:0] code);
    bus.cond_ctx = ctx; bus.cond_code = code; #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drv(1'b0, 2'd0, 4'hF, 1'b0, 32'h0, 32'h0, 32'h0);
    sr(1'b0, 1'b0);
    bus.cond_ctx = 2'd0; bus.cond_code = 4'hE;
    bus2.valid_in = 1'b0; bus2.ctx_sel = 2'd0; bus2.op_code = 4'hF; bus2.s_flag = 1'b0;
    bus2.in1 = 8'h0; bus2.in2 = 8'h0; bus2.result = 8'h0;
    bus2.save = 1'b0; bus2.restore = 1'b0; bus2.cond_ctx = 2'd0; bus2.cond_code = 4'hE;
  endtask

  task automatic test_reset();
    tests++; if (bus.flags_out !== 4'b0000) begin fails++; $display("FAIL reset_flags_out got %b exp 0000", bus.flags_out); end
    tests++; if (bus.flags_vld !== 1'b0) begin fails++; $display("FAIL reset_flags_vld got %b exp 0", bus.flags_vld); end
    cq(2'd0, 4'hE);
    tests++; if (bus.cond_pass !== 1'b1) begin fails++; $display("FAIL reset_al got %b exp 1", bus.cond_pass); end
    cq(2'd0, 4'h0);
    tests++; if (bus.cond_pass !== 1'b0) begin fails++; $display("FAIL reset_eq got %b exp 0", bus.cond_pass); end
  endtask

  task automatic test_arith();
    // add carry-out to zero
    drv(1'b1, 2'd0, 4'h0, 1'b1, 32'hFFFF_FFFF, 32'h1, 32'h0); cq(2'd0, 4'h0);
    tests++; if (bus.cond_pass !== 1'b1) begin fails++; $display("FAIL add_eq_bypass got %b exp 1", bus.cond_pass); end
    step();
    tests++; if (bus.flags_out !== 4'b0110) begin fails++; $display("FAIL add_carry got %b exp 0110", bus.flags_out); end
    tests++; if (bus.flags_vld !== 1'b1) begin fails++; $display("FAIL add_vld got %b exp 1", bus.flags_vld); end
    // sub with signed overflow, no borrow
    drv(1'b1, 2'd0, 4'h1, 1'b1, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF); cq(2'd0, 4'h6);
    tests++; if (bus.cond_pass !== 1'b1) begin fails++; $display("FAIL sub_vs_bypass got %b exp 1", bus.cond_pass); end
    step();
    tests++; if (bus.flags_out !== 4'b0011) begin fails++; $display("FAIL sub_ovf got %b exp 0011", bus.flags_out); end
    // other op keeps C and V
    drv(1'b1, 2'd0, 4'h2, 1'b1, 32'h0, 32'h0, 32'h8000_0000); step();
    tests++; if (bus.flags_out !== 4'b1011) begin fails++; $display("FAIL logic_keep_cv got %b exp 1011", bus.flags_out); end
    drv(1'b1, 2'd0, 4'h0, 1'b1, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000); step();
    tests++; if (bus.flags_out !== 4'b1001) begin fails++; $display("FAIL add_ovf got %b exp 1001", bus.flags_out); end
    drv(1'b1, 2'd0, 4'h1, 1'b1, 32'h0, 32'h1, 32'hFFFF_FFFF); step();
    tests++; if (bus.flags_out !== 4'b1000) begin fails++; $display("FAIL sub_borrow got %b exp 1000", bus.flags_out); end
    drv(1'b0, 2'd0, 4'hF, 1'b0, 32'h0, 32'h0, 32'h0); step();
    tests++; if (bus.flags_vld !== 1'b0) begin fails++; $display("FAIL vld_drop got %b exp 0", bus.flags_vld); end
  endtask

  task automatic test_no_write();
    drv(1'b1, 2'd0, 4'hF, 1'b1, 32'hFFFF_FFFF, 32'h1, 32'h0); step();
    tests++; if (bus.flags_vld !== 1'b0) begin fails++; $display("FAIL nf_vld got %b exp 0", bus.flags_vld); end
    tests++; if (bus.flags_out !== 4'b1000) begin fails++; $display("FAIL nf_hold got %b exp 1000", bus.flags_out); end
    drv(1'b1, 2'd0, 4'h0, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0); step();
    tests++; if (bus.flags_vld !== 1'b0) begin fails++; $display("FAIL s0_vld got %b exp 0", bus.flags_vld); end
    tests++; if (bus.flags_out !== 4'b1000) begin fails++; $display("FAIL s0_hold got %b exp 1000", bus.flags_out); end
    drv(1'b0, 2'd0, 4'hF, 1'b0, 32'h0, 32'h0, 32'h0); cq(2'd0, 4'h4);
    tests++; if (bus.cond_pass !== 1'b1) begin fails++; $display("FAIL s0_live_mi got %b exp 1", bus.cond_pass); end
  endtask

  task automatic test_save_restore();
    drv(1'b1, 2'd1, 4'hB, 1'b0, 32'h0, 32'h0, 32'h9); step();
    tests++; if (bus.flags_out !== 4'b1001) begin fails++; $display("FAIL ld9 got %b exp 1001", bus.flags_out); end
    drv(1'b0, 2'd1, 4'hF, 1'b0, 32'h0, 32'h0, 32'h0); sr(1'b1, 1'b0); step();
    sr(1'b0, 1'b0); drv(1'b1, 2'd1, 4'hB, 1'b0, 32'h0, 32'h0, 32'h0); step();
    tests++; if (bus.flags_out !== 4'b0000) begin fails++; $display("FAIL ld0 got %b exp 0000", bus.flags_out); end
    drv(1'b0, 2'd1, 4'hF, 1'b0, 32'h0, 32'h0, 32'h0); sr(1'b0, 1'b1); step();
    tests++; if (bus.flags_vld !== 1'b0) begin fails++; $display("FAIL restore_vld got %b exp 0", bus.flags_vld); end
    tests++; if (bus.flags_out !== 4'b0000) begin fails++; $display("FAIL restore_fout got %b exp 0000", bus.flags_out); end
    sr(1'b0, 1'b0); cq(2'd1, 4'h4);
    tests++; if (bus.cond_pass !== 1'b1) begin fails++; $display("FAIL restore_mi got %b exp 1", bus.cond_pass); end
    cq(2'd1, 4'h6);
    tests++; if (bus.cond_pass !== 1'b1) begin fails++; $display("FAIL restore_vs got %b exp 1", bus.cond_pass); end
    cq(2'd0, 4'hB);
    tests++; if (bus.cond_pass !== 1'b1) begin fails++; $display("FAIL ctx0_lt got %b exp 1", bus.cond_pass); end
    cq(2'd0, 4'h2);
    tests++; if (bus.cond_pass !== 1'b0) begin fails++; $display("FAIL ctx0_cs got %b exp 0", bus.cond_pass); end
    // swap: live 0010 <-> shadow 1001
    drv(1'b1, 2'd1, 4'hB, 1'b0, 32'h0, 32'h0, 32'h2); step();
    drv(1'b0, 2'd1, 4'hF, 1'b0, 32'h0, 32'h0, 32'h0); sr(1'b1, 1'b1); step();
    sr(1'b0, 1'b0); cq(2'd1, 4'h4);
    tests++; if (bus.cond_pass !== 1'b1) begin fails++; $display("FAIL swap_live_mi got %b exp 1", bus.cond_pass); end
    // restore drops same-cycle update: live <- 0010
    drv(1'b1, 2'd1, 4'hB, 1'b0, 32'h0, 32'h0, 32'hF); sr(1'b0, 1'b1); step();
    tests++; if (bus.flags_out !== 4'b0010) begin fails++; $display("FAIL drop_fout got %b exp 0010", bus.flags_out); end
    tests++; if (bus.flags_vld !== 1'b0) begin fails++; $display("FAIL drop_vld got %b exp 0", bus.flags_vld); end
    drv(1'b0, 2'd1, 4'hF, 1'b0, 32'h0, 32'h0, 32'h0); sr(1'b0, 1'b0); cq(2'd1, 4'h8);
    tests++; if (bus.cond_pass !== 1'b1) begin fails++; $display("FAIL drop_hi got %b exp 1", bus.cond_pass); end
    // save + update on ctx3: shadow 0000, live 0101
    drv(1'b1, 2'd3, 4'hB, 1'b0, 32'h0, 32'h0, 32'h5); sr(1'b1, 1'b0); step();
    tests++; if (bus.flags_out !== 4'b0101) begin fails++; $display("FAIL saveupd_fout got %b exp 0101", bus.flags_out); end
    drv(1'b0, 2'd3, 4'hF, 1'b0, 32'h0, 32'h0, 32'h0); sr(1'b0, 1'b1); step();
    sr(1'b0, 1'b0); cq(2'd3, 4'h0);
    tests++; if (bus.cond_pass !== 1'b0) begin fails++; $display("FAIL saveupd_restore_eq got %b exp 0", bus.cond_pass); end
  endtask

  task automatic test_bypass();
    drv(1'b1, 2'd2, 4'hB, 1'b0, 32'h0, 32'h0, 32'h8); cq(2'd2, 4'hB);
    tests++; if (bus.cond_pass !== 1'b1) begin fails++; $display("FAIL bypass_lt got %b exp 1", bus.cond_pass); end
    cq(2'd2, 4'hA);
    tests++; if (bus.cond_pass !== 1'b0) begin fails++; $display("FAIL bypass_ge got %b exp 0", bus.cond_pass); end
    step();
    drv(1'b0, 2'd0, 4'hF, 1'b0, 32'h0, 32'h0, 32'h0); cq(2'd2, 4'hB);
    tests++; if (bus.cond_pass !== 1'b1) begin fails++; $display("FAIL stored_lt got %b exp 1", bus.cond_pass); end
  endtask

  task automatic test_bad_ctx();
    bus2.valid_in = 1'b1; bus2.ctx_sel = 2'd3; bus2.op_code = 4'hB; bus2.result = 8'hF;
    bus2.cond_ctx = 2'd3; bus2.cond_code = 4'hE; #1;
    tests++; if (bus2.cond_pass !== 1'b0) begin fails++; $display("FAIL badctx_al got %b exp 0", bus2.cond_pass); end
    step();
    tests++; if (bus2.flags_vld !== 1'b0) begin fails++; $display("FAIL badctx_vld got %b exp 0", bus2.flags_vld); end
    bus2.ctx_sel = 2'd2; bus2.op_code = 4'h0; bus2.s_flag = 1'b1;
    bus2.in1 = 8'hFF; bus2.in2 = 8'h01; bus2.result = 8'h00; bus2.cond_ctx = 2'd2; #1;
    tests++; if (bus2.cond_pass !== 1'b1) begin fails++; $display("FAIL ctx2_al got %b exp 1", bus2.cond_pass); end
    step();
    tests++; if (bus2.flags_out !== 4'b0110) begin fails++; $display("FAIL w8_add got %b exp 0110", bus2.flags_out); end
    bus2.valid_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    drv(1'b1, 2'd0, 4'hB, 1'b0, 32'h0, 32'h0, 32'h4); step();
    drv(1'b1, 2'd3, 4'hB, 1'b0, 32'h0, 32'h0, 32'h1); step();
    drv(1'b0, 2'd0, 4'hF, 1'b0, 32'h0, 32'h0, 32'h0); cq(2'd0, 4'h0);
    tests++; if (bus.cond_pass !== 1'b1) begin fails++; $display("FAIL pre_rst_eq got %b exp 1", bus.cond_pass); end
    drv(1'b1, 2'd3, 4'hB, 1'b0, 32'h0, 32'h0, 32'hF);
    #2 rst_n = 1'b0; #1;
    tests++; if (bus.flags_out !== 4'b0000) begin fails++; $display("FAIL rst_fout got %b exp 0000", bus.flags_out); end
    tests++; if (bus.flags_vld !== 1'b0) begin fails++; $display("FAIL rst_vld got %b exp 0", bus.flags_vld); end
    cq(2'd0, 4'h0);
    tests++; if (bus.cond_pass !== 1'b0) begin fails++; $display("FAIL rst_eq got %b exp 0", bus.cond_pass); end
    cq(2'd2, 4'h4);
    tests++; if (bus.cond_pass !== 1'b0) begin fails++; $display("FAIL rst_ctx2_mi got %b exp 0", bus.cond_pass); end
    step();
    drv(1'b0, 2'd0, 4'hF, 1'b0, 32'h0, 32'h0, 32'h0);
    #2 rst_n = 1'b1;
    step();
    tests++; if (bus.flags_out !== 4'b0000) begin fails++; $display("FAIL post_rst_fout got %b exp 0000", bus.flags_out); end
    cq(2'd3, 4'h1);
    tests++; if (bus.cond_pass !== 1'b1) begin fails++; $display("FAIL post_rst_ctx3_ne got %b exp 1", bus.cond_pass); end
    cq(2'd1, 4'h2);
    tests++; if (bus.cond_pass !== 1'b0) begin fails++; $display("FAIL post_rst_ctx1_cs got %b exp 0", bus.cond_pass); end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    test_reset();
    test_arith();
    test_no_write();
    test_save_restore();
    test_bypass();
    test_bad_ctx();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
